// File: rtl/mfp_ahb_interconnect.sv
// AHB-lite interconnect: one master, N_SLAVES slaves, mask/base address decode,
// registered data-phase select, and a default slave that answers unmapped transfers with ERROR.
module mfp_ahb_interconnect #(
    parameter int                    N_SLAVES = 6,
    parameter logic [32*N_SLAVES-1:0] SLV_BASE = {32'h1F000000, 32'h20000000, 32'h1F400000,
                                                  32'h1F800000, 32'h00000000, 32'h1FC00000},
    parameter logic [32*N_SLAVES-1:0] SLV_MASK = {32'hFFC00000, 32'hF0000000, 32'hFFC00000,
                                                  32'hFFC00000, 32'hF0000000, 32'hFFC00000},
    parameter int                    CNT_W    = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [31:0]             HADDR,
    input  logic [1:0]              HTRANS,
    output logic [N_SLAVES-1:0]     HSEL,
    input  logic [32*N_SLAVES-1:0]  HRDATA_S,
    input  logic [N_SLAVES-1:0]     HREADYOUT_S,
    input  logic [N_SLAVES-1:0]     HRESP_S,
    output logic [31:0]             HRDATA,
    output logic                    HREADY,
    output logic                    HRESP,
    input  logic                    ERR_CLR,
    output logic [31:0]             DECERR_ADDR,
    output logic [CNT_W-1:0]        DECERR_CNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } dflt_state_t;

    dflt_state_t         state;
    logic                dflt_hready;
    logic                dflt_hresp;
    logic [N_SLAVES-1:0] hsel;
    logic                found;
    logic                dflt;
    logic [N_SLAVES-1:0] sel_d;
    logic                dflt_d;
    logic                new_err;

    // Priority decode: the lowest-numbered matching slave wins, so HSEL stays one-hot.
    always_comb begin
        hsel  = '0;
        found = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!found &&
                ((HADDR & SLV_MASK[32*i +: 32]) == (SLV_BASE[32*i +: 32] & SLV_MASK[32*i +: 32]))) begin
                hsel[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

    assign HSEL    = hsel;
    assign dflt    = ~found;
    assign new_err = HREADY & dflt & HTRANS[1];

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_d  <= '0;
            dflt_d <= 1'b0;
        end else if (HREADY) begin
            sel_d  <= hsel;
            dflt_d <= dflt;
        end
    end

    // Response comes from whoever owns the data phase; the default slave covers the unselected case.
    always_comb begin
        HRDATA = '0;
        HREADY = dflt_hready;
        HRESP  = dflt_hresp;
        if (!dflt_d) begin
            for (int i = 0; i < N_SLAVES; i++) begin
                if (sel_d[i]) begin
                    HRDATA = HRDATA_S[32*i +: 32];
                    HREADY = HREADYOUT_S[i];
                    HRESP  = HRESP_S[i];
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= IDLE;
            dflt_hready <= 1'b1;
            dflt_hresp  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (new_err) begin
                        state       <= ERR1;
                        dflt_hready <= 1'b0;
                        dflt_hresp  <= 1'b1;
                    end
                end
                ERR1: begin
                    state       <= ERR2;
                    dflt_hready <= 1'b1;
                    dflt_hresp  <= 1'b1;
                end
                ERR2: begin
                    if (new_err) begin
                        state       <= ERR1;
                        dflt_hready <= 1'b0;
                        dflt_hresp  <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        dflt_hready <= 1'b1;
                        dflt_hresp  <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    dflt_hready <= 1'b1;
                    dflt_hresp  <= 1'b0;
                end
            endcase
        end
    end

    // A new error beats a simultaneous clear: address is captured and the count restarts at one.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            DECERR_ADDR <= '0;
            DECERR_CNT  <= '0;
        end else if (new_err) begin
            DECERR_ADDR <= HADDR;
            if (ERR_CLR)
                DECERR_CNT <= CNT_W'(1);
            else if (DECERR_CNT != {CNT_W{1'b1}})
                DECERR_CNT <= DECERR_CNT + CNT_W'(1);
        end else if (ERR_CLR) begin
            DECERR_ADDR <= '0;
            DECERR_CNT  <= '0;
        end
    end

endmodule

// File: tb/tb_mfp_ahb_interconnect.sv
// Directed bench for mfp_ahb_interconnect; a second instance with CNT_W = 2 covers counter saturation.
module tb_mfp_ahb_interconnect;

    localparam int N = 6;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [N-1:0] RDY_ALL = 6'b111111;

    logic            HCLK;
    logic            HRESET;
    logic [31:0]     HADDR;
    logic [1:0]      HTRANS;
    logic [N-1:0]    HSEL;
    logic [32*N-1:0] HRDATA_S;
    logic [N-1:0]    HREADYOUT_S;
    logic [N-1:0]    HRESP_S;
    logic [31:0]     HRDATA;
    logic            HREADY;
    logic            HRESP;
    logic            ERR_CLR;
    logic [31:0]     DECERR_ADDR;
    logic [7:0]      DECERR_CNT;

    logic [N-1:0]    hsel2;
    logic [31:0]     hrdata2;
    logic            hready2;
    logic            hresp2;
    logic [31:0]     decerr_addr2;
    logic [1:0]      decerr_cnt2;

    int checks = 0;
    int errors = 0;

    mfp_ahb_interconnect dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(HSEL),
        .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .ERR_CLR(ERR_CLR),
        .DECERR_ADDR(DECERR_ADDR), .DECERR_CNT(DECERR_CNT)
    );

    mfp_ahb_interconnect #(.CNT_W(2)) dut2 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HSEL(hsel2),
        .HRDATA_S(HRDATA_S), .HREADYOUT_S(HREADYOUT_S), .HRESP_S(HRESP_S),
        .HRDATA(hrdata2), .HREADY(hready2), .HRESP(hresp2), .ERR_CLR(ERR_CLR),
        .DECERR_ADDR(decerr_addr2), .DECERR_CNT(decerr_cnt2)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Inputs change on the falling edge; outputs are sampled 1 time unit later, well clear of the rising edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [1:0] trans,
                                 input logic [N-1:0] rdy, input logic [N-1:0] resp,
                                 input logic clr, input logic rst);
        @(negedge HCLK);
        HADDR       = addr;
        HTRANS      = trans;
        HREADYOUT_S = rdy;
        HRESP_S     = resp;
        ERR_CLR     = clr;
        HRESET      = rst;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        HRDATA_S = {32'hA0000005, 32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hDEADBEEF};
        HADDR = '0; HTRANS = T_IDLE; HREADYOUT_S = RDY_ALL; HRESP_S = '0; ERR_CLR = 1'b0; HRESET = 1'b1;

        // Reset state
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b1);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("rst_hready", 32'(HREADY), 32'd1);
        checkOutput("rst_hresp", 32'(HRESP), 32'd0);
        checkOutput("rst_hrdata", HRDATA, 32'h0);
        checkOutput("rst_cnt", 32'(DECERR_CNT), 32'd0);
        checkOutput("rst_addr", DECERR_ADDR, 32'h0);

        // Mapped read from slave 0
        applyStimulus(32'h1FC00010, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("s0_hsel", 32'(HSEL), 32'b000001);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("s0_hrdata", HRDATA, 32'hDEADBEEF);
        checkOutput("s0_hready", 32'(HREADY), 32'd1);
        checkOutput("s0_hresp", 32'(HRESP), 32'd0);
        checkOutput("zero_hsel", 32'(HSEL), 32'b000010);

        // Slave 2 inserts three wait states while slave 1's address is already on the bus
        applyStimulus(32'h1F800004, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("s2_hsel", 32'(HSEL), 32'b000100);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h00000100, T_NONSEQ, 6'b111011, '0, 1'b0, 1'b0);
            checkOutput("s2_wait_hready", 32'(HREADY), 32'd0);
            checkOutput("s2_wait_hrdata", HRDATA, 32'hA0000002);
        end
        applyStimulus(32'h00000100, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("s2_done_hready", 32'(HREADY), 32'd1);
        checkOutput("s2_done_hrdata", HRDATA, 32'hA0000002);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("s1_hrdata", HRDATA, 32'hA0000001);

        // Slave error response passes straight through
        applyStimulus(32'h1F400000, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("s3_hsel", 32'(HSEL), 32'b001000);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, 6'b001000, 1'b0, 1'b0);
        checkOutput("s3_hresp", 32'(HRESP), 32'd1);
        checkOutput("s3_hrdata", HRDATA, 32'hA0000003);

        // Single unmapped transfer
        applyStimulus(32'h30000000, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("um_hsel", 32'(HSEL), 32'b0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("um_err1_hready", 32'(HREADY), 32'd0);
        checkOutput("um_err1_hresp", 32'(HRESP), 32'd1);
        checkOutput("um_addr", DECERR_ADDR, 32'h30000000);
        checkOutput("um_cnt", 32'(DECERR_CNT), 32'd1);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("um_err2_hready", 32'(HREADY), 32'd1);
        checkOutput("um_err2_hresp", 32'(HRESP), 32'd1);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("um_idle_hready", 32'(HREADY), 32'd1);
        checkOutput("um_idle_hresp", 32'(HRESP), 32'd0);

        // Clear the log
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b1, 1'b0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("clr_cnt", 32'(DECERR_CNT), 32'd0);
        checkOutput("clr_addr", DECERR_ADDR, 32'h0);

        // Back-to-back unmapped transfers
        applyStimulus(32'h30000000, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        applyStimulus(32'h40000000, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("b2b_err1a_hready", 32'(HREADY), 32'd0);
        checkOutput("b2b_err1a_hresp", 32'(HRESP), 32'd1);
        applyStimulus(32'h40000000, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("b2b_err2a_hready", 32'(HREADY), 32'd1);
        checkOutput("b2b_err2a_hresp", 32'(HRESP), 32'd1);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("b2b_err1b_hready", 32'(HREADY), 32'd0);
        checkOutput("b2b_err1b_hresp", 32'(HRESP), 32'd1);
        checkOutput("b2b_cnt", 32'(DECERR_CNT), 32'd2);
        checkOutput("b2b_addr", DECERR_ADDR, 32'h40000000);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("b2b_err2b_hready", 32'(HREADY), 32'd1);
        checkOutput("b2b_err2b_hresp", 32'(HRESP), 32'd1);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("b2b_idle_hresp", 32'(HRESP), 32'd0);

        // IDLE transfer to an unmapped address completes with OKAY
        applyStimulus(32'h30000000, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("idle_um_hready", 32'(HREADY), 32'd1);
        checkOutput("idle_um_hresp", 32'(HRESP), 32'd0);
        checkOutput("idle_um_hrdata", HRDATA, 32'h0);
        checkOutput("idle_um_cnt", 32'(DECERR_CNT), 32'd2);

        // Clear coincident with a new error
        applyStimulus(32'h30000000, T_NONSEQ, RDY_ALL, '0, 1'b1, 1'b0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("clrerr_cnt", 32'(DECERR_CNT), 32'd1);
        checkOutput("clrerr_addr", DECERR_ADDR, 32'h30000000);
        checkOutput("clrerr_hready", 32'(HREADY), 32'd0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b1, 1'b0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("sat_pre_cnt2", 32'(decerr_cnt2), 32'd0);

        // Five back-to-back errors: 8-bit counter reaches 5, 2-bit counter saturates at 3
        for (int k = 0; k < 5; k++) begin
            applyStimulus(32'h30000000 + 32'(k * 16), T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
            applyStimulus(32'h30000000 + 32'(k * 16), T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        end
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("sat_cnt2", 32'(decerr_cnt2), 32'd3);
        checkOutput("sat_cnt", 32'(DECERR_CNT), 32'd5);
        checkOutput("sat_addr2", decerr_addr2, 32'h30000040);
        checkOutput("sat_hready2", 32'(hready2), 32'd1);
        checkOutput("sat_hresp2", 32'(hresp2), 32'd1);
        checkOutput("sat_hsel2", 32'(hsel2), 32'b000010);
        checkOutput("sat_hrdata2", hrdata2, 32'h0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);

        // Reset while the default slave sits in ERR1
        applyStimulus(32'h30000000, T_NONSEQ, RDY_ALL, '0, 1'b0, 1'b0);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b1);
        checkOutput("rst_err1_hready", 32'(HREADY), 32'd0);
        checkOutput("rst_err1_hresp", 32'(HRESP), 32'd1);
        applyStimulus(32'h0, T_IDLE, RDY_ALL, '0, 1'b0, 1'b0);
        checkOutput("rst_after_hready", 32'(HREADY), 32'd1);
        checkOutput("rst_after_hresp", 32'(HRESP), 32'd0);
        checkOutput("rst_after_cnt", 32'(DECERR_CNT), 32'd0);
        checkOutput("rst_after_addr", DECERR_ADDR, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
